// File: rtl/mini_cpu_data_path_pkg.sv
// Shared constants for the mini CPU datapath:
// ALU opcodes, branch conditions, IR field positions, RAM size.
package mini_cpu_data_path_pkg;

  localparam int MEM_DEPTH = 512;
  localparam int MEM_AW    = 9;

  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;
  localparam int BR_LSB = 19;
  localparam int C_W    = 19;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_SHR  = 5'b00111,
    OP_SHRA = 5'b01000,
    OP_SHL  = 5'b01001,
    OP_ROR  = 5'b01010,
    OP_ROL  = 5'b01011,
    OP_MUL  = 5'b01111,
    OP_DIV  = 5'b10000,
    OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_ZERO = 2'b00,
    BR_NZ   = 2'b01,
    BR_POS  = 2'b10,
    BR_NEG  = 2'b11
  } br_cond_e;

endpackage

// File: rtl/mini_cpu_data_path_alu.sv
// Combinational ALU: A=Y, B=bus, 64-bit result {hi,lo}.
// IncPC forces B+1 regardless of opcode.
module mini_cpu_alu
  import mini_cpu_data_path_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [4:0]  i_op,
  input  logic        i_inc,
  output logic [63:0] o_res
);

  logic [63:0]        w_prod;
  logic [63:0]        w_dbl_r;
  logic [63:0]        w_dbl_l;
  logic signed [31:0] w_sa;
  logic signed [31:0] w_sb;
  logic signed [31:0] w_q;
  logic signed [31:0] w_r;
  logic [31:0]        w_lo;
  logic [31:0]        w_hi;
  logic [4:0]         w_sh;

  assign w_sh    = i_b[4:0];
  assign w_sa    = i_a;
  assign w_sb    = i_b;
  assign w_prod  = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_dbl_r = {i_a, i_a} >> w_sh;
  assign w_dbl_l = {i_a, i_a} << w_sh;
  assign w_q     = (i_b == '0) ? '0 : w_sa / w_sb;
  assign w_r     = (i_b == '0) ? '0 : w_sa % w_sb;

  always_comb begin
    w_lo = '0;
    w_hi = '0;
    if (i_inc) begin
      w_lo = i_b + 32'd1;
      w_hi = {32{w_lo[31]}};
    end else begin
      case (i_op)
        OP_ADD: begin
          w_lo = i_a + i_b;
          w_hi = {32{w_lo[31]}};
        end
        OP_SUB: begin
          w_lo = i_a - i_b;
          w_hi = {32{w_lo[31]}};
        end
        OP_AND:  w_lo = i_a & i_b;
        OP_OR:   w_lo = i_a | i_b;
        OP_SHR:  w_lo = i_a >> w_sh;
        OP_SHRA: w_lo = w_sa >>> w_sh;
        OP_SHL:  w_lo = i_a << w_sh;
        OP_ROR:  w_lo = w_dbl_r[31:0];
        OP_ROL:  w_lo = w_dbl_l[63:32];
        OP_MUL:  {w_hi, w_lo} = w_prod;
        OP_DIV: begin
          w_lo = w_q;
          w_hi = w_r;
        end
        OP_NEG:  w_lo = -i_b;
        OP_NOT:  w_lo = ~i_b;
        default: w_lo = '0;
      endcase
    end
  end

  assign o_res = {w_hi, w_lo};

endmodule

// File: rtl/mini_cpu_data_path.sv
// Single-bus 32-bit datapath of the mini CPU; all strobes come
// from an external control FSM. Internals exported for debug.
module mini_cpu_data_path
  import mini_cpu_data_path_pkg::*;
(
  input  logic        Clock,
  input  logic        clear,
  input  logic        Read,
  input  logic        Write,
  input  logic        strobe,
  input  logic        BAout,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Rin,
  input  logic        Rout,
  input  logic [31:0] input_data,
  input  logic        IRin,
  input  logic [4:0]  op,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        PCout,
  input  logic        MDRout,
  input  logic        InPortout,
  input  logic        Yout,
  input  logic        RAMout,
  input  logic        Cout,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        ZHighin,
  input  logic        Zlowin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        OutPortin,
  input  logic        Yin,
  input  logic        MARin,
  input  logic        IncPC,
  output logic [31:0] BusOut,
  output logic [31:0] mdrData,
  output logic [31:0] ZHighWire,
  output logic [31:0] ZLowWire,
  output logic [31:0] BusMuxInR0,
  output logic [31:0] BusMuxInR1,
  output logic [31:0] BusMuxInR2,
  output logic [31:0] BusMuxInR3,
  output logic [31:0] BusMuxInR4,
  output logic [31:0] BusMuxInR5,
  output logic [31:0] BusMuxInR6,
  output logic [31:0] BusMuxInR7,
  output logic [31:0] BusMuxInR8,
  output logic [31:0] BusMuxInR9,
  output logic [31:0] BusMuxInR10,
  output logic [31:0] BusMuxInR11,
  output logic [31:0] BusMuxInR12,
  output logic [31:0] BusMuxInR13,
  output logic [31:0] BusMuxInR14,
  output logic [31:0] BusMuxInR15,
  output logic [31:0] BusMuxInZhigh,
  output logic [31:0] BusMuxInZlow,
  output logic [31:0] BusMuxInPCout,
  output logic [31:0] BusMuxInInPortout,
  output logic [31:0] BusMuxInYout,
  output logic [31:0] BusMuxInHI,
  output logic [31:0] BusMuxInLO,
  output logic [31:0] BusMuxInRamout,
  output logic [31:0] output_data,
  output logic [31:0] irOut,
  output logic        branchCompare,
  output logic        R0out,  R1out,  R2out,  R3out,
  output logic        R4out,  R5out,  R6out,  R7out,
  output logic        R8out,  R9out,  R10out, R11out,
  output logic        R12out, R13out, R14out, R15out,
  output logic        R0in,  R1in,  R2in,  R3in,
  output logic        R4in,  R5in,  R6in,  R7in,
  output logic        R8in,  R9in,  R10in, R11in,
  output logic        R12in, R13in, R14in, R15in,
  output logic [3:0]  to_decode
);

  logic [31:0]       r_r [16];
  logic [31:0]       r_pc, r_ir, r_mdr, r_y;
  logic [31:0]       r_hi, r_lo, r_zhi, r_zlo;
  logic [31:0]       r_inp, r_outp;
  logic [MEM_AW-1:0] r_mar;
  logic [31:0]       r_mem [MEM_DEPTH];

  logic [31:0] w_bus, w_c, w_ram;
  logic [63:0] w_alu;
  logic [3:0]  w_dec;
  logic [15:0] w_oh, w_rin, w_rout;

  always_comb begin
    w_dec = '0;
    if (Gra)      w_dec = r_ir[RA_LSB+:4];
    else if (Grb) w_dec = r_ir[RB_LSB+:4];
    else if (Grc) w_dec = r_ir[RC_LSB+:4];
  end

  assign w_oh   = 16'd1 << w_dec;
  assign w_rin  = {16{Rin}} & w_oh;
  assign w_rout = {16{Rout | BAout}} & w_oh;
  assign w_c    = {{(32-C_W){r_ir[C_W-1]}}, r_ir[C_W-1:0]};
  assign w_ram  = r_mem[r_mar];

  always_comb begin
    w_bus = '0;
    if (|w_rout) begin
      for (int k = 0; k < 16; k++)
        if (w_rout[k]) w_bus = r_r[k];
      // base-address mode reads R0 as constant zero
      if (w_rout[0] && BAout) w_bus = '0;
    end
    else if (HIout)     w_bus = r_hi;
    else if (LOout)     w_bus = r_lo;
    else if (Zhighout)  w_bus = r_zhi;
    else if (Zlowout)   w_bus = r_zlo;
    else if (PCout)     w_bus = r_pc;
    else if (MDRout)    w_bus = r_mdr;
    else if (InPortout) w_bus = r_inp;
    else if (Yout)      w_bus = r_y;
    else if (RAMout)    w_bus = w_ram;
    else if (Cout)      w_bus = w_c;
  end

  mini_cpu_alu u_alu (
    .i_a   (r_y),
    .i_b   (w_bus),
    .i_op  (op),
    .i_inc (IncPC),
    .o_res (w_alu)
  );

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      for (int k = 0; k < 16; k++) r_r[k] <= '0;
      r_pc   <= '0;
      r_ir   <= '0;
      r_mar  <= '0;
      r_mdr  <= '0;
      r_y    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_zhi  <= '0;
      r_zlo  <= '0;
      r_inp  <= '0;
      r_outp <= '0;
    end else begin
      for (int k = 0; k < 16; k++)
        if (w_rin[k]) r_r[k] <= w_bus;
      if (PCin)      r_pc   <= w_bus;
      if (IRin)      r_ir   <= w_bus;
      if (MARin)     r_mar  <= w_bus[MEM_AW-1:0];
      if (MDRin)     r_mdr  <= Read ? w_ram : w_bus;
      if (Yin)       r_y    <= w_bus;
      if (HIin)      r_hi   <= w_bus;
      if (LOin)      r_lo   <= w_bus;
      if (ZHighin)   r_zhi  <= w_alu[63:32];
      if (Zlowin)    r_zlo  <= w_alu[31:0];
      if (strobe)    r_inp  <= input_data;
      if (OutPortin) r_outp <= w_bus;
    end
  end

  // RAM keeps its contents across clear
  always_ff @(posedge Clock) begin
    if (Write) r_mem[r_mar] <= r_mdr;
  end

  always_comb begin
    branchCompare = 1'b0;
    case (br_cond_e'(r_ir[BR_LSB+:2]))
      BR_ZERO: branchCompare = (w_bus == '0);
      BR_NZ:   branchCompare = (w_bus != '0);
      BR_POS:  branchCompare = !w_bus[31] && (w_bus != '0);
      BR_NEG:  branchCompare = w_bus[31];
      default: branchCompare = 1'b0;
    endcase
  end

  assign BusOut            = w_bus;
  assign mdrData           = r_mdr;
  assign ZHighWire         = w_alu[63:32];
  assign ZLowWire          = w_alu[31:0];
  assign BusMuxInZhigh     = r_zhi;
  assign BusMuxInZlow      = r_zlo;
  assign BusMuxInPCout     = r_pc;
  assign BusMuxInInPortout = r_inp;
  assign BusMuxInYout      = r_y;
  assign BusMuxInHI        = r_hi;
  assign BusMuxInLO        = r_lo;
  assign BusMuxInRamout    = w_ram;
  assign output_data       = r_outp;
  assign irOut             = r_ir;
  assign to_decode         = w_dec;

  assign BusMuxInR0  = r_r[0];
  assign BusMuxInR1  = r_r[1];
  assign BusMuxInR2  = r_r[2];
  assign BusMuxInR3  = r_r[3];
  assign BusMuxInR4  = r_r[4];
  assign BusMuxInR5  = r_r[5];
  assign BusMuxInR6  = r_r[6];
  assign BusMuxInR7  = r_r[7];
  assign BusMuxInR8  = r_r[8];
  assign BusMuxInR9  = r_r[9];
  assign BusMuxInR10 = r_r[10];
  assign BusMuxInR11 = r_r[11];
  assign BusMuxInR12 = r_r[12];
  assign BusMuxInR13 = r_r[13];
  assign BusMuxInR14 = r_r[14];
  assign BusMuxInR15 = r_r[15];

  assign {R15out, R14out, R13out, R12out,
          R11out, R10out, R9out,  R8out,
          R7out,  R6out,  R5out,  R4out,
          R3out,  R2out,  R1out,  R0out} = w_rout;

  assign {R15in, R14in, R13in, R12in,
          R11in, R10in, R9in,  R8in,
          R7in,  R6in,  R5in,  R4in,
          R3in,  R2in,  R1in,  R0in} = w_rin;

endmodule

// File: tb/tb_mini_cpu_data_path.sv
// Scoreboard bench for mini_cpu_data_path: reset, fetch,
// load/store, ALU table, decode and branch conditions.
module tb_mini_cpu_data_path;

  logic        Clock, clear;
  logic        Read, Write, strobe, BAout;
  logic        Gra, Grb, Grc, Rin, Rout;
  logic [31:0] input_data;
  logic        IRin;
  logic [4:0]  op;
  logic        HIout, LOout, Zhighout, Zlowout, PCout;
  logic        MDRout, InPortout, Yout, RAMout, Cout;
  logic        HIin, LOin, ZHighin, Zlowin, PCin;
  logic        MDRin, OutPortin, Yin, MARin, IncPC;
  logic [31:0] BusOut, mdrData, ZHighWire, ZLowWire;
  logic [31:0] bm_r [16];
  logic [31:0] bm_zh, bm_zl, bm_pc, bm_inp, bm_y;
  logic [31:0] bm_hi, bm_lo, bm_ram;
  logic [31:0] output_data, irOut;
  logic        branchCompare;
  logic [15:0] rout, rin;
  logic [3:0]  to_decode;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  mini_cpu_data_path dut (
    .Clock(Clock), .clear(clear),
    .Read(Read), .Write(Write), .strobe(strobe),
    .BAout(BAout), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout),
    .input_data(input_data), .IRin(IRin), .op(op),
    .HIout(HIout), .LOout(LOout),
    .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout),
    .InPortout(InPortout), .Yout(Yout),
    .RAMout(RAMout), .Cout(Cout),
    .HIin(HIin), .LOin(LOin),
    .ZHighin(ZHighin), .Zlowin(Zlowin),
    .PCin(PCin), .MDRin(MDRin),
    .OutPortin(OutPortin), .Yin(Yin),
    .MARin(MARin), .IncPC(IncPC),
    .BusOut(BusOut), .mdrData(mdrData),
    .ZHighWire(ZHighWire), .ZLowWire(ZLowWire),
    .BusMuxInR0(bm_r[0]),   .BusMuxInR1(bm_r[1]),
    .BusMuxInR2(bm_r[2]),   .BusMuxInR3(bm_r[3]),
    .BusMuxInR4(bm_r[4]),   .BusMuxInR5(bm_r[5]),
    .BusMuxInR6(bm_r[6]),   .BusMuxInR7(bm_r[7]),
    .BusMuxInR8(bm_r[8]),   .BusMuxInR9(bm_r[9]),
    .BusMuxInR10(bm_r[10]), .BusMuxInR11(bm_r[11]),
    .BusMuxInR12(bm_r[12]), .BusMuxInR13(bm_r[13]),
    .BusMuxInR14(bm_r[14]), .BusMuxInR15(bm_r[15]),
    .BusMuxInZhigh(bm_zh), .BusMuxInZlow(bm_zl),
    .BusMuxInPCout(bm_pc),
    .BusMuxInInPortout(bm_inp),
    .BusMuxInYout(bm_y),
    .BusMuxInHI(bm_hi), .BusMuxInLO(bm_lo),
    .BusMuxInRamout(bm_ram),
    .output_data(output_data), .irOut(irOut),
    .branchCompare(branchCompare),
    .R0out(rout[0]),   .R1out(rout[1]),
    .R2out(rout[2]),   .R3out(rout[3]),
    .R4out(rout[4]),   .R5out(rout[5]),
    .R6out(rout[6]),   .R7out(rout[7]),
    .R8out(rout[8]),   .R9out(rout[9]),
    .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]),
    .R14out(rout[14]), .R15out(rout[15]),
    .R0in(rin[0]),   .R1in(rin[1]),
    .R2in(rin[2]),   .R3in(rin[3]),
    .R4in(rin[4]),   .R5in(rin[5]),
    .R6in(rin[6]),   .R7in(rin[7]),
    .R8in(rin[8]),   .R9in(rin[9]),
    .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]),
    .R14in(rin[14]), .R15in(rin[15]),
    .to_decode(to_decode)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic idle();
    Read = 0; Write = 0; strobe = 0; BAout = 0;
    Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0;
    IRin = 0; op = '0;
    HIout = 0; LOout = 0; Zhighout = 0; Zlowout = 0;
    PCout = 0; MDRout = 0; InPortout = 0; Yout = 0;
    RAMout = 0; Cout = 0;
    HIin = 0; LOin = 0; ZHighin = 0; Zlowin = 0;
    PCin = 0; MDRin = 0; OutPortin = 0; Yin = 0;
    MARin = 0; IncPC = 0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_inport(input logic [31:0] v);
    idle();
    input_data = v;
    strobe = 1;
    tick();
    idle();
  endtask

  task automatic bus_in(input logic [31:0] v);
    set_inport(v);
    InPortout = 1;
    #1;
  endtask

  task automatic to_ir(input logic [31:0] v);
    set_inport(v);
    InPortout = 1; IRin = 1;
    tick();
    idle();
  endtask

  task automatic to_reg(input int k, input logic [31:0] v);
    to_ir(32'(k) << 23);
    set_inport(v);
    InPortout = 1; Gra = 1; Rin = 1;
    tick();
    idle();
  endtask

  task automatic ram_wr(input logic [31:0] a, input logic [31:0] v);
    set_inport(a);
    InPortout = 1; MARin = 1;
    tick();
    set_inport(v);
    InPortout = 1; MDRin = 1;
    tick();
    idle();
    Write = 1;
    tick();
    idle();
  endtask

  task automatic do_load();
    Grb = 1; BAout = 1; Yin = 1;
    #1;
    pop_chk({31'b0, rout[0]});
    tick(); idle();
    pop_chk(bm_y);
    Cout = 1; op = 5'b00011; ZHighin = 1; Zlowin = 1;
    tick(); idle();
    Zlowout = 1; MARin = 1;
    tick(); idle();
    Read = 1; MDRin = 1;
    tick(); idle();
    Gra = 1; Rin = 1; MDRout = 1;
    tick(); idle();
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] y, b, lo, hi;
  } alu_row_t;

  alu_row_t alu_tab[14] = '{
    '{5'b00011, 32'd7,          32'hFFFF_FFF6, 32'hFFFF_FFFD, 32'hFFFF_FFFF},
    '{5'b00100, 32'd5,          32'd3,         32'd2,         32'd0},
    '{5'b00101, 32'hF0F0_F0F0,  32'h0FF0_0FF0, 32'h00F0_00F0, 32'd0},
    '{5'b00110, 32'hF000_0000,  32'h0000_000F, 32'hF000_000F, 32'd0},
    '{5'b00111, 32'h8000_0000,  32'd4,         32'h0800_0000, 32'd0},
    '{5'b01000, 32'h8000_0000,  32'd4,         32'hF800_0000, 32'd0},
    '{5'b01001, 32'd3,          32'd33,        32'd6,         32'd0},
    '{5'b01010, 32'd1,          32'd1,         32'h8000_0000, 32'd0},
    '{5'b01011, 32'h8000_0001,  32'd4,         32'h0000_0018, 32'd0},
    '{5'b01111, 32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFA, 32'hFFFF_FFFF},
    '{5'b10000, 32'd17,         32'd5,         32'd3,         32'd2},
    '{5'b10000, 32'd17,         32'd0,         32'd0,         32'd0},
    '{5'b10001, 32'd9,          32'd5,         32'hFFFF_FFFB, 32'd0},
    '{5'b00000, 32'd9,          32'd5,         32'd0,         32'd0}
  };

  initial begin
    idle();
    input_data = '0;
    clear = 1;
    tick();
    tick();
    clear = 0;

    push("rst_pc", 32'd0);
    push("rst_ir", 32'd0);
    push("rst_r5", 32'd0);
    pop_chk(bm_pc);
    pop_chk(irOut);
    pop_chk(bm_r[5]);

    // clear mid-run
    ram_wr(32'd0, 32'hA5A5_0001);
    to_reg(3, 32'd5);
    set_inport(32'd7);
    InPortout = 1; PCin = 1;
    tick(); idle();
    push("pre_r3", 32'd5);
    push("pre_pc", 32'd7);
    pop_chk(bm_r[3]);
    pop_chk(bm_pc);
    #1 clear = 1;
    #1;
    for (int k = 0; k < 16; k++)
      push($sformatf("clr_r%0d", k), 32'd0);
    for (int k = 0; k < 16; k++) pop_chk(bm_r[k]);
    push("clr_zh", 0); push("clr_zl", 0);
    push("clr_pc", 0); push("clr_inp", 0);
    push("clr_y", 0);  push("clr_hi", 0);
    push("clr_lo", 0); push("clr_mdr", 0);
    push("clr_out", 0);
    push("clr_ram0", 32'hA5A5_0001);
    pop_chk(bm_zh); pop_chk(bm_zl);
    pop_chk(bm_pc); pop_chk(bm_inp);
    pop_chk(bm_y);  pop_chk(bm_hi);
    pop_chk(bm_lo); pop_chk(mdrData);
    pop_chk(output_data);
    pop_chk(bm_ram);
    #1 clear = 0;

    // instruction fetch
    push("fetch_inc", 32'd1);
    push("fetch_pc", 32'd1);
    push("fetch_ir", 32'hA5A5_0001);
    PCout = 1; MARin = 1; IncPC = 1; ZHighin = 1; Zlowin = 1;
    #1;
    pop_chk(ZLowWire);
    tick(); idle();
    Zlowout = 1; PCin = 1;
    tick(); idle();
    Read = 1; MDRin = 1;
    tick(); idle();
    MDRout = 1; IRin = 1;
    tick(); idle();
    pop_chk(bm_pc);
    pop_chk(irOut);

    // ld R1,0x54(R2)
    ram_wr(32'h64, 32'h0000_CAFE);
    to_reg(2, 32'h10);
    to_ir(32'h0090_0054);
    push("ld_r2out", 32'd0);
    push("ld_y", 32'h10);
    push("ld_r1", 32'h0000_CAFE);
    push("ld_mdr", 32'h0000_CAFE);
    do_load();
    pop_chk(bm_r[1]);
    pop_chk(mdrData);

    // ld R4,0x54(R0): BAout reads R0 as zero
    ram_wr(32'h54, 32'h0000_BEEF);
    ram_wr(32'hED, 32'h0000_DEAD);
    to_reg(0, 32'h99);
    to_ir(32'h0200_0054);
    push("ba_r0out", 32'd1);
    push("ba_y", 32'd0);
    push("ba_r4", 32'h0000_BEEF);
    do_load();
    pop_chk(bm_r[4]);

    // store then read back through the bus
    ram_wr(32'h20, 32'h0000_1234);
    push("st_mdr", 32'h1234);
    push("st_ram", 32'h1234);
    push("st_bus", 32'h1234);
    push("st_out", 32'h1234);
    RAMout = 1;
    #1;
    pop_chk(mdrData);
    pop_chk(bm_ram);
    pop_chk(BusOut);
    OutPortin = 1;
    tick(); idle();
    pop_chk(output_data);

    set_inport(32'h77);
    InPortout = 1; HIin = 1;
    tick(); idle();
    push("hi_load", 32'h77);
    pop_chk(bm_hi);

    // IR field select and decode
    to_ir(32'h02B3_8000);
    push("dec_ra", 32'd5);
    push("dec_rin", 32'h0020);
    push("dec_rc", 32'd7);
    push("dec_rout", 32'h0080);
    push("dec_none", 32'd0);
    Gra = 1; Rin = 1;
    #1;
    pop_chk(32'(to_decode));
    pop_chk(32'(rin));
    idle();
    Grc = 1; Rout = 1;
    #1;
    pop_chk(32'(to_decode));
    pop_chk(32'(rout));
    idle();
    #1;
    pop_chk(32'(rin | rout));

    // branch conditions
    to_ir(32'h0010_0000);
    push("br_pos50", 1);
    push("br_pos0", 0);
    push("br_negm1", 1);
    push("br_neg5", 0);
    push("br_nz0", 0);
    bus_in(32'd50); pop_chk(32'(branchCompare));
    bus_in(32'd0);  pop_chk(32'(branchCompare));
    idle();
    to_ir(32'h0018_0000);
    bus_in(32'hFFFF_FFFF); pop_chk(32'(branchCompare));
    bus_in(32'd5);         pop_chk(32'(branchCompare));
    idle();
    to_ir(32'h0008_0000);
    bus_in(32'd0); pop_chk(32'(branchCompare));
    idle();

    // ALU table, combinational result then latched Z
    foreach (alu_tab[i]) begin
      push($sformatf("alu%0d_lo", i), alu_tab[i].lo);
      push($sformatf("alu%0d_hi", i), alu_tab[i].hi);
      push($sformatf("alu%0d_zl", i), alu_tab[i].lo);
      push($sformatf("alu%0d_zh", i), alu_tab[i].hi);
      set_inport(alu_tab[i].y);
      InPortout = 1; Yin = 1;
      tick();
      set_inport(alu_tab[i].b);
      InPortout = 1; op = alu_tab[i].op;
      ZHighin = 1; Zlowin = 1;
      #1;
      pop_chk(ZLowWire);
      pop_chk(ZHighWire);
      tick(); idle();
      pop_chk(bm_zl);
      pop_chk(bm_zh);
    end

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
